// File: rtl/key_frontend.sv
// key_frontend -- keypad input stage for the lock sequence detector.
//
// Takes two raw, asynchronous, bouncy push-buttons and turns each accepted
// press into a single-cycle symbol code for the detector. Each key is
// synchronised through two flops and then debounced. A press that overlaps
// the other key is rejected and reported as a conflict.
//
// Optional build macro:
//   KEY_LOCKOUT_EN  - after a conflict, discard all presses for
//                     LOCKOUT_CYCLES cycles and drive 'locked' high during
//                     that window. When undefined, 'locked' is tied low and
//                     a conflict only pulses err_conflict.
//
// Parameters:
//   DB_CYCLES       consecutive stable samples needed to accept a change (>=2)
//   CNT_W           width of the debounce and lockout counters
//   LOCKOUT_CYCLES  length of the conflict lockout window
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   key_a, key_b  raw buttons, asynchronous, active-high
//   sym           00 none, 01 'a', 10 'b' (11 never driven)
//   sym_valid     high exactly when sym != 00
//   err_conflict  one-cycle pulse when a press is rejected as a conflict
//   locked        high while the conflict lockout is active
module key_frontend #(
  parameter int DB_CYCLES      = 4,
  parameter int CNT_W          = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_a,
  input  logic       key_b,
  output logic [1:0] sym,
  output logic       sym_valid,
  output logic       err_conflict,
  output logic       locked
);

  // Reject parameter sets the counters cannot represent.
  if (DB_CYCLES < 2 || LOCKOUT_CYCLES < 1 ||
      DB_CYCLES > (2 ** CNT_W) || LOCKOUT_CYCLES > (2 ** CNT_W)) begin : g_bad_params
    $error("key_frontend: invalid DB_CYCLES/LOCKOUT_CYCLES/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  // Bit 0 carries key 'a', bit 1 carries key 'b' throughout.
  logic [1:0]       key_raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       db;
  logic [CNT_W-1:0] cnt [2];

  logic [1:0] press;
  logic       conflict;
  logic       lock_hold;
  logic [1:0] sym_d;
  logic       err_d;

  assign key_raw = {key_b, key_a};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // cnt counts consecutive s2 samples that disagree with db; any agreeing
  // sample restarts it, so a glitch can never be accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db     <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the cycle just before db rises; releases never produce one.
  assign press[0] = s2[0] & ~db[0] & (cnt[0] == DB_LAST);
  assign press[1] = s2[1] & ~db[1] & (cnt[1] == DB_LAST);

  assign conflict = (press[0] & press[1]) |
                    (press[0] & db[1]) |
                    (press[1] & db[0]);

`ifdef KEY_LOCKOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [CNT_W-1:0] lock_cnt;

  // Loaded with LOCKOUT_CYCLES-1 so locked is high for exactly
  // LOCKOUT_CYCLES cycles, starting alongside the err_conflict pulse.
  // Conflicts are only seen while unlocked, so the window never restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked   <= 1'b0;
      lock_cnt <= '0;
    end else if (locked) begin
      if (lock_cnt == '0) begin
        locked <= 1'b0;
      end else begin
        lock_cnt <= lock_cnt - 1'b1;
      end
    end else if (conflict) begin
      locked   <= 1'b1;
      lock_cnt <= LOCK_LAST;
    end
  end

  assign lock_hold = locked;
`else
  assign locked    = 1'b0;
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    sym_d = 2'b00;
    err_d = 1'b0;
    if (!lock_hold) begin
      if (conflict) begin
        err_d = 1'b1;
      end else if (press[0]) begin
        sym_d = 2'b01;
      end else if (press[1]) begin
        sym_d = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym          <= 2'b00;
      sym_valid    <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      sym          <= sym_d;
      sym_valid    <= (sym_d != 2'b00);
      err_conflict <= err_d;
    end
  end

endmodule

// File: tb/tb_key_frontend.sv
// tb_key_frontend -- directed self-checking bench for key_frontend
// (DB_CYCLES=4, LOCKOUT_CYCLES=16). Inputs change just after a rising edge;
// outputs are sampled 1 time unit after each rising edge. "tick i" is the
// i-th rising edge of a scenario, and expected codes are placed at the tick
// where they become visible.
module tb_key_frontend;

  logic       clk;
  logic       rst_n;
  logic       key_a;
  logic       key_b;
  logic [1:0] sym;
  logic       sym_valid;
  logic       err_conflict;
  logic       locked;

  int n_tests;
  int n_fail;

`ifdef KEY_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  key_frontend #(
    .DB_CYCLES(4),
    .CNT_W(8),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_a(key_a),
    .key_b(key_b),
    .sym(sym),
    .sym_valid(sym_valid),
    .err_conflict(err_conflict),
    .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_sym;
    rst_n = 1'b0;
    key_a = 1'b1;
    key_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if ({sym, sym_valid, err_conflict, locked} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold tick %0d: outputs=%b required=00000", i,
                 {sym, sym_valid, err_conflict, locked});
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_sym = (i == 6) ? 2'b01 : 2'b00;
      n_tests++;
      if (sym !== exp_sym || sym_valid !== (exp_sym != 2'b00) ||
          err_conflict !== 1'b0 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_emit tick %0d: sym=%b valid=%b err=%b locked=%b required sym=%b valid=%b err=0 locked=0",
                 i, sym, sym_valid, err_conflict, locked, exp_sym, exp_sym != 2'b00);
      end
    end
    key_a = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    logic       pat [5];
    logic [1:0] exp_sym;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      key_b = pat[k];
      tick();
      n_tests++;
      if (sym !== 2'b00 || sym_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_quiet step %0d: sym=%b valid=%b required sym=00 valid=0",
                 k, sym, sym_valid);
      end
    end
    key_b = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) key_b = 1'b0;
      tick();
      exp_sym = (i == 6) ? 2'b10 : 2'b00;
      n_tests++;
      if (sym !== exp_sym || sym_valid !== (exp_sym != 2'b00) || err_conflict !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_emit tick %0d: sym=%b valid=%b err=%b required sym=%b valid=%b err=0",
                 i, sym, sym_valid, err_conflict, exp_sym, exp_sym != 2'b00);
      end
    end
  endtask

  task automatic test_sequence();
    logic [1:0] exp_sym;
    logic [5:0] seen;
    int         pulses;
    pulses = 0;
    seen   = '0;
    for (int i = 1; i <= 65; i++) begin
      key_a = (i <= 10) || (i > 40 && i <= 50);
      key_b = (i > 20 && i <= 30);
      tick();
      case (i)
        6, 46:   exp_sym = 2'b01;
        26:      exp_sym = 2'b10;
        default: exp_sym = 2'b00;
      endcase
      if (sym != 2'b00) begin
        if (pulses < 3) seen = {seen[3:0], sym};
        pulses++;
      end
      n_tests++;
      if (sym !== exp_sym || sym_valid !== (exp_sym != 2'b00) || err_conflict !== 1'b0) begin
        n_fail++;
        $display("FAIL sequence tick %0d: sym=%b valid=%b err=%b required sym=%b valid=%b err=0",
                 i, sym, sym_valid, err_conflict, exp_sym, exp_sym != 2'b00);
      end
    end
    n_tests++;
    if (pulses !== 3 || seen !== 6'b01_10_01) begin
      n_fail++;
      $display("FAIL sequence_aba: pulses=%0d codes=%b required pulses=3 codes=011001",
               pulses, seen);
    end
  endtask

  task automatic test_simultaneous();
    logic exp_err;
    logic exp_lock;
    for (int i = 1; i <= 60; i++) begin
      key_a = (i <= 20);
      key_b = (i <= 20);
      tick();
      exp_err  = (i == 6);
      exp_lock = LOCK_EN && (i >= 6) && (i <= 21);
      n_tests++;
      if (sym !== 2'b00 || sym_valid !== 1'b0 || err_conflict !== exp_err ||
          locked !== exp_lock) begin
        n_fail++;
        $display("FAIL simultaneous tick %0d: sym=%b valid=%b err=%b locked=%b required sym=00 valid=0 err=%b locked=%b",
                 i, sym, sym_valid, err_conflict, locked, exp_err, exp_lock);
      end
    end
  endtask

  task automatic test_overlap();
    logic [1:0] exp_sym;
    logic       exp_err;
    logic       exp_lock;
    for (int i = 1; i <= 65; i++) begin
      key_a = (i <= 20);
      key_b = (i > 10 && i <= 20) || (i >= 40 && i < 50);
      tick();
      case (i)
        6:       exp_sym = 2'b01;
        45:      exp_sym = 2'b10;
        default: exp_sym = 2'b00;
      endcase
      exp_err  = (i == 16);
      exp_lock = LOCK_EN && (i >= 16) && (i <= 31);
      n_tests++;
      if (sym !== exp_sym || sym_valid !== (exp_sym != 2'b00) ||
          err_conflict !== exp_err || locked !== exp_lock) begin
        n_fail++;
        $display("FAIL overlap tick %0d: sym=%b valid=%b err=%b locked=%b required sym=%b valid=%b err=%b locked=%b",
                 i, sym, sym_valid, err_conflict, locked,
                 exp_sym, exp_sym != 2'b00, exp_err, exp_lock);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [1:0] exp_sym;
    key_a = 1'b1;
    key_b = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      rst_n = (i != 5);
      tick();
      exp_sym = (i == 11) ? 2'b01 : 2'b00;
      n_tests++;
      if (sym !== exp_sym || sym_valid !== (exp_sym != 2'b00) ||
          err_conflict !== 1'b0 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_press tick %0d: sym=%b valid=%b err=%b locked=%b required sym=%b valid=%b err=0 locked=0",
                 i, sym, sym_valid, err_conflict, locked, exp_sym, exp_sym != 2'b00);
      end
    end
    rst_n = 1'b1;
    key_a = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    key_a   = 1'b0;
    key_b   = 1'b0;
    test_reset();
    test_bounce();
    test_sequence();
    test_simultaneous();
    test_overlap();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_frontend.md
Name: key_frontend

Overview:
- Keypad input stage that sits directly upstream of the lock sequence detector.
- Turns two raw, asynchronous, bouncy push-buttons (key_a, key_b) into clean single-cycle symbol codes on a 2-bit bus: 00 = none, 01 = 'a', 10 = 'b'. The detector consumes these codes every cycle.
- Synchronises and debounces each button and emits exactly one code per press.
- Rejects simultaneous or overlapping presses and flags them as conflicts.

Parameters:
- DB_CYCLES, 4: consecutive stable synchroniser samples needed to accept a level change (≥2).
- CNT_W, 8: width of the debounce and lockout counters. Must hold both DB_CYCLES and LOCKOUT_CYCLES.
- LOCKOUT_CYCLES, 16: length of the conflict lockout window. Used only with KEY_LOCKOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- key_a  in  1  raw button 'a', asynchronous, active-high.
- key_b  in  1  raw button 'b', asynchronous, active-high.
- sym  out  2  symbol code for the detector: 00 none, 01 'a', 10 'b'. Value 11 is never driven.
- sym_valid  out  1  high exactly in cycles where sym != 00.
- err_conflict  out  1  one-cycle pulse when a press is rejected as a conflict.
- locked  out  1  high while the conflict lockout is active. Tied 0 without KEY_LOCKOUT_EN.

Behaviour:
- Reset (rst_n=0 at a clk edge): every register clears to 0. This covers synchroniser flops, debounced levels db_a/db_b, counters, sym, sym_valid, err_conflict and locked. Reset overrides all other activity, including mid-debounce and mid-lockout.
- Synchroniser: two flops per key (s1 then s2). Only s2 is used downstream.
- Debounce, per key:
  - Keep a counter cnt and a debounced level db.
  - At an edge where s2 == db: cnt <= 0.
  - At an edge where s2 != db and cnt == DB_CYCLES-1: db <= s2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Result: a level is accepted only after DB_CYCLES consecutive differing s2 samples. Any single-cycle glitch restarts the count.
- Press event: press_x = (s2_x=1, db_x=0, cnt_x=DB_CYCLES-1), evaluated combinationally in the cycle before db_x rises. Releases generate no event.
- Output register, updated every edge:
  - press_a, no press_b, db_b=0 → sym <= 01.
  - press_b, no press_a, db_a=0 → sym <= 10.
  - press_a and press_b in the same cycle, or a press on one key while the other's db is 1 → sym <= 00, err_conflict <= 1.
  - Otherwise sym <= 00 and err_conflict <= 0.
  - sym_valid <= (next sym != 00).
- Latency: if key_a goes high and stays high, s1 captures it at edge E0. sym=01 is then visible after edge E(DB_CYCLES+1) and lasts exactly one cycle.
- No auto-repeat: a held key produces a single code. A new code needs a debounced release followed by a new debounced press.
- Both keys held, then one released: no event is produced; the remaining held key does not emit.
- A key held through reset deassertion is debounced afresh and emits one code, because db restarts at 0.
- Output sequencing: at most one code every DB_CYCLES+1 cycles per key, so the output never emits codes on consecutive cycles for the same key.

Optional Feature:
- KEY_LOCKOUT_EN defined:
  - Any conflict sets locked <= 1 and loads the lockout counter.
  - locked then stays high for exactly LOCKOUT_CYCLES cycles, starting the cycle err_conflict is high.
  - While locked is high, every press event is discarded: sym stays 00 and no new err_conflict is raised.
  - Debouncing continues normally during lockout, so held keys do not emit when lockout ends.
  - A conflict can only occur while unlocked, so lockout is never restarted from within itself.
- KEY_LOCKOUT_EN undefined: no lockout counter is built, locked is constant 0, and conflicts only pulse err_conflict.

Test Plan (DB_CYCLES=4, LOCKOUT_CYCLES=16):
- Reset with rst_n=0 for 3 edges while key_a=1 → all outputs 0 during reset. After release, sym=01 for one cycle, 6 edges after the first post-reset edge; then 00 while key_a stays high.
- key_b bounces 1,0,1,1,0 then holds 1 → no code during bounce. sym=10 exactly once, 6 edges after the start of the stable 1; sym_valid matches.
- Press a, release, press b, release, press a (each held 10 cycles, gaps of 10) → sym sequence 01, 10, 01 with exactly three one-cycle pulses. The detector downstream sees "aba".
- key_a and key_b rise at the same edge and hold → sym stays 00 and err_conflict pulses once. With KEY_LOCKOUT_EN, locked is high for 16 cycles.
- Hold key_a (sym=01 emitted), then press key_b while a is still held → sym stays 00 and err_conflict=1. Release both, press b → sym=10 (after lockout has expired, if enabled).
- Pull rst_n low for 1 edge at cnt_a=2 of a key_a press → no code from the interrupted press. The press completes anew and emits 01 6 edges after reset release.
